sat_round_pipe: RTL

SAT_ROUND_PIPE -- requirements
Module: sat_round_pipe

---
 rtl/sat_round_pipe.sv | 93 +++++++++
 1 files changed

// File: rtl/sat_round_pipe.sv
// sat_round_pipe: two-stage round-then-clamp pipeline with valid/ready handshakes
// and a sticky saturation flag plus a saturating event counter.
module sat_round_pipe #(
  parameter int DATA_W   = 40,
  parameter int WIDE_W   = 32,
  parameter int NARROW_W = 16,
  parameter int RND_POS  = 16,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] value_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              do_sat_i,
  input  logic              mode_i,
  input  logic              round_i,
  output logic [DATA_W-1:0] value_o,
  output logic              did_sat_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              clr_i,
  output logic              sat_flag_o,
  output logic [CNT_W-1:0]  sat_cnt_o
);
  localparam logic signed [DATA_W:0] w_max   = {{(DATA_W+1-WIDE_W){1'b0}}, {(WIDE_W-1){1'b1}}};
  localparam logic signed [DATA_W:0] w_min   = {{(DATA_W+2-WIDE_W){1'b1}}, {(WIDE_W-1){1'b0}}};
  localparam logic signed [DATA_W:0] n_max   = {{(DATA_W+1-NARROW_W){1'b0}}, {(NARROW_W-1){1'b1}}};
  localparam logic signed [DATA_W:0] n_min   = {{(DATA_W+2-NARROW_W){1'b1}}, {(NARROW_W-1){1'b0}}};
  localparam logic signed [DATA_W:0] rnd_add = {{(DATA_W+2-RND_POS){1'b0}}, 1'b1, {(RND_POS-1){1'b0}}};
  localparam logic [DATA_W-1:0]      keep    = {{(DATA_W-RND_POS){1'b1}}, {RND_POS{1'b0}}};
  logic                     s1_valid, s1_sat, s1_mode, s1_round;
  logic signed [DATA_W:0]   s1_r, r_in, hi, lo;
  logic                     s1_en, s2_en, over, under, clamp, sat_hs;
  logic [DATA_W-1:0]        res, res_m;
  assign s2_en   = !valid_o || ready_i;
  assign s1_en   = !s1_valid || s2_en;
  assign ready_o = s1_en;
  // One extra bit of headroom keeps the rounding add from wrapping before the range check.
  assign r_in = $signed({value_i[DATA_W-1], value_i}) + ((round_i && !mode_i) ? rnd_add : '0);
  always_comb begin
    hi    = s1_mode ? n_max : w_max;
    lo    = s1_mode ? n_min : w_min;
    over  = s1_r > hi;
    under = s1_r < lo;
    clamp = s1_sat && (over || under);
    res   = !s1_sat ? s1_r[DATA_W-1:0] : over ? hi[DATA_W-1:0] : under ? lo[DATA_W-1:0] : s1_r[DATA_W-1:0];
    res_m = s1_round ? (res & keep) : res;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_sat   <= 1'b0;
      s1_mode  <= 1'b0;
      s1_round <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_r     <= r_in;
        s1_sat   <= do_sat_i;
        s1_mode  <= mode_i;
        s1_round <= round_i && !mode_i;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o   <= 1'b0;
      value_o   <= '0;
      did_sat_o <= 1'b0;
    end else if (s2_en) begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        value_o   <= res_m;
        did_sat_o <= clamp;
      end
    end
  end
  assign sat_hs = valid_o && ready_i && did_sat_o;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sat_flag_o <= 1'b0;
      sat_cnt_o  <= '0;
    end else if (clr_i) begin
      sat_flag_o <= sat_hs;
      sat_cnt_o  <= sat_hs ? CNT_W'(1) : '0;
    end else if (sat_hs) begin
      sat_flag_o <= 1'b1;
      sat_cnt_o  <= (sat_cnt_o == '1) ? sat_cnt_o : sat_cnt_o + CNT_W'(1);
    end
  end
endmodule
